// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: derived widths, counter
// initial values and width-parametrised saturating arithmetic helpers.
package bp_pkg;

  // Number of index bits for a direct-mapped table of the given depth.
  function automatic int idx_w(input int entries);
    return $clog2(entries);
  endfunction

  // Tag width: PC bits left above the index field and the ignored byte offset.
  function automatic int tag_w(input int addr_w, input int entries);
    return addr_w - $clog2(entries) - 2;
  endfunction

  // Weakly not-taken: largest value whose MSB is still clear.
  function automatic int init_nt(input int ctr_w);
    return (1 << (ctr_w - 1)) - 1;
  endfunction

  // Weakly taken: smallest value whose MSB is set.
  function automatic int init_t(input int ctr_w);
    return 1 << (ctr_w - 1);
  endfunction

  // Saturating increment of a w-bit value carried in a 32-bit container.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] lim;
    lim = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= lim) ? lim : (v + 32'd1);
  endfunction

  // Saturating decrement of a w-bit value; holds at zero.
  function automatic logic [31:0] sat_dec(input logic [31:0] v, input int w);
    logic [31:0] unusedWidth;
    unusedWidth = 32'(w);
    return (v == 32'd0) ? 32'd0 : (v - 32'd1);
  endfunction

endpackage

// File: rtl/bp_table.sv
// Direct-mapped BTB entry array: valid/tag/target/counter per entry, two
// combinational read ports (IF lookup and resolution evaluation) and one
// synchronous write port. Reset and clear both invalidate every entry.
module bp_table
  import bp_pkg::*;
#(
  parameter  int ENTRIES = 16,
  parameter  int CTR_W   = 2,
  parameter  int ADDR_W  = 32,
  localparam int IDX_W   = idx_w(ENTRIES),
  localparam int TAG_W   = tag_w(ADDR_W, ENTRIES)
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              i_clear,
  // lookup port driven by the IF-stage PC
  input  logic [IDX_W-1:0]  i_lkIdx,
  input  logic [TAG_W-1:0]  i_lkTag,
  output logic              o_lkHit,
  output logic [CTR_W-1:0]  o_lkCtr,
  output logic [ADDR_W-1:0] o_lkTarget,
  // evaluation port driven by the resolved-branch PC
  input  logic [IDX_W-1:0]  i_evIdx,
  input  logic [TAG_W-1:0]  i_evTag,
  output logic              o_evHit,
  output logic [CTR_W-1:0]  o_evCtr,
  output logic [ADDR_W-1:0] o_evTarget,
  // write port
  input  logic              i_wrEn,
  input  logic [IDX_W-1:0]  i_wrIdx,
  input  logic [TAG_W-1:0]  i_wrTag,
  input  logic [ADDR_W-1:0] i_wrTarget,
  input  logic [CTR_W-1:0]  i_wrCtr
);

  localparam logic [CTR_W-1:0] INIT_NT_V = CTR_W'(init_nt(CTR_W));

  logic              r_valid  [ENTRIES];
  logic [TAG_W-1:0]  r_tag    [ENTRIES];
  logic [ADDR_W-1:0] r_target [ENTRIES];
  logic [CTR_W-1:0]  r_ctr    [ENTRIES];

  // Valid bits and counters: reset/clear take priority over any write.
  always_ff @(posedge clk_i) begin
    if (!rst_n || i_clear) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= INIT_NT_V;
      end
    end else if (i_wrEn) begin
      r_valid[i_wrIdx] <= 1'b1;
      r_ctr[i_wrIdx]   <= i_wrCtr;
    end
  end

  // Tags and targets carry no reset; they are meaningless while invalid.
  always_ff @(posedge clk_i) begin
    if (i_wrEn) begin
      r_tag[i_wrIdx]    <= i_wrTag;
      r_target[i_wrIdx] <= i_wrTarget;
    end
  end

  assign o_lkHit    = r_valid[i_lkIdx] && (r_tag[i_lkIdx] == i_lkTag);
  assign o_lkCtr    = r_ctr[i_lkIdx];
  assign o_lkTarget = r_target[i_lkIdx];

  assign o_evHit    = r_valid[i_evIdx] && (r_tag[i_evIdx] == i_evTag);
  assign o_evCtr    = r_ctr[i_evIdx];
  assign o_evTarget = r_target[i_evIdx];

endmodule

// File: rtl/branch_predictor_btb.sv
// Dynamic branch predictor top level: combinational next-PC prediction for
// the IF stage, mispredict detection and training policy for the
// resolution stage, plus saturating update/mispredict statistics.
module branch_predictor_btb
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2,
  parameter int ADDR_W  = 32,
  parameter int CNT_W   = 16
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] if_pc_i,
  output logic              pred_hit_o,
  output logic              pred_taken_o,
  output logic [ADDR_W-1:0] pred_target_o,
  input  logic              upd_valid_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [ADDR_W-1:0] upd_target_i,
  input  logic              clear_i,
  output logic              mispredict_o,
  output logic [CNT_W-1:0]  upd_count_o,
  output logic [CNT_W-1:0]  miss_count_o
);

  localparam int IDX_W = idx_w(ENTRIES);
  localparam int TAG_W = tag_w(ADDR_W, ENTRIES);
  localparam logic [CTR_W-1:0] INIT_T_V = CTR_W'(init_t(CTR_W));

  logic [IDX_W-1:0]  w_lkIdx, w_evIdx;
  logic [TAG_W-1:0]  w_lkTag, w_evTag;
  logic              w_lkHit, w_evHit;
  logic [CTR_W-1:0]  w_lkCtr, w_evCtr;
  logic [ADDR_W-1:0] w_lkTarget, w_evTarget;
  logic              w_evTaken;
  logic              w_wrEn;
  logic [CTR_W-1:0]  w_wrCtr;
  logic [ADDR_W-1:0] w_wrTarget;
  logic              w_unused;
  logic [CNT_W-1:0]  r_updCount, r_missCount;

  // Byte-offset bits never take part in indexing or tagging.
  assign w_unused = ^{if_pc_i[1:0], upd_pc_i[1:0]};

  assign w_lkIdx = if_pc_i[IDX_W+1:2];
  assign w_lkTag = if_pc_i[ADDR_W-1:IDX_W+2];
  assign w_evIdx = upd_pc_i[IDX_W+1:2];
  assign w_evTag = upd_pc_i[ADDR_W-1:IDX_W+2];

  bp_table #(
    .ENTRIES (ENTRIES),
    .CTR_W   (CTR_W),
    .ADDR_W  (ADDR_W)
  ) u_table (
    .clk_i      (clk_i),
    .rst_n      (rst_n),
    .i_clear    (clear_i),
    .i_lkIdx    (w_lkIdx),
    .i_lkTag    (w_lkTag),
    .o_lkHit    (w_lkHit),
    .o_lkCtr    (w_lkCtr),
    .o_lkTarget (w_lkTarget),
    .i_evIdx    (w_evIdx),
    .i_evTag    (w_evTag),
    .o_evHit    (w_evHit),
    .o_evCtr    (w_evCtr),
    .o_evTarget (w_evTarget),
    .i_wrEn     (w_wrEn),
    .i_wrIdx    (w_evIdx),
    .i_wrTag    (w_evTag),
    .i_wrTarget (w_wrTarget),
    .i_wrCtr    (w_wrCtr)
  );

  assign pred_hit_o    = w_lkHit;
  assign pred_taken_o  = w_lkHit && w_lkCtr[CTR_W-1];
  assign pred_target_o = w_lkHit ? w_lkTarget : '0;

  // The resolved branch is judged against what the table would predict now.
  assign w_evTaken    = w_evHit && w_evCtr[CTR_W-1];
  assign mispredict_o = upd_valid_i &&
                        ((w_evTaken != upd_taken_i) ||
                         (upd_taken_i && w_evTaken && (w_evTarget != upd_target_i)));

  // Training policy: hits move the counter, taken misses allocate, a clear drops the write.
  always_comb begin
    w_wrEn     = 1'b0;
    w_wrCtr    = w_evCtr;
    w_wrTarget = w_evTarget;
    if (upd_valid_i && !clear_i) begin
      if (w_evHit) begin
        w_wrEn = 1'b1;
        if (upd_taken_i) begin
          w_wrCtr    = CTR_W'(sat_inc(32'(w_evCtr), CTR_W));
          w_wrTarget = upd_target_i;
        end else begin
          w_wrCtr    = CTR_W'(sat_dec(32'(w_evCtr), CTR_W));
        end
      end else if (upd_taken_i) begin
        w_wrEn     = 1'b1;
        w_wrCtr    = INIT_T_V;
        w_wrTarget = upd_target_i;
      end
    end
  end

  // Statistics saturate at all-ones and survive a clear, but not a reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      r_updCount  <= '0;
      r_missCount <= '0;
    end else begin
      if (upd_valid_i && (r_updCount != '1)) begin
        r_updCount <= r_updCount + 1'b1;
      end
      if (mispredict_o && (r_missCount != '1)) begin
        r_missCount <= r_missCount + 1'b1;
      end
    end
  end

  assign upd_count_o  = r_updCount;
  assign miss_count_o = r_missCount;

endmodule

// File: doc/branch_predictor_btb.md
# branch_predictor_btb

Parametrised dynamic branch predictor for the pipelined CPU: a direct-mapped branch target buffer with per-entry saturating direction counters, looked up combinationally by the IF-stage PC and trained by the branch-resolution stage. It replaces static "predict not-taken plus flush" with a next-PC prediction for the PC source mux. It flags mispredicts so the pipeline can flush. It keeps saturating branch and mispredict statistics.

## Interface
Parameters:
- ENTRIES, 16: BTB entries; power of two, ≥2. IDX_W = log2(ENTRIES).
- CTR_W, 2: direction counter width, ≥1.
- ADDR_W, 32: PC width. TAG_W = ADDR_W − IDX_W − 2.
- CNT_W, 16: statistics counter width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n  in  1  reset; synchronous and active-low.
- if_pc_i  in  ADDR_W  IF-stage PC to predict.
- pred_hit_o  out  1  valid entry with matching tag for if_pc_i.
- pred_taken_o  out  1  predict taken; hit AND counter MSB.
- pred_target_o  out  ADDR_W  stored target on hit, else 0.
- upd_valid_i  in  1  a resolved branch is presented this cycle.
- upd_pc_i  in  ADDR_W  PC of the resolved branch.
- upd_taken_i  in  1  actual direction.
- upd_target_i  in  ADDR_W  actual taken target.
- clear_i  in  1  invalidate all entries.
- mispredict_o  out  1  the resolved branch disagrees with what the table predicts now.
- upd_count_o  out  CNT_W  number of updates, saturating.
- miss_count_o  out  CNT_W  number of mispredicts, saturating.

## Operation
- Index = pc[IDX_W+1:2]; tag = pc[ADDR_W-1:IDX_W+2]. pc[1:0] is ignored.
- Entry contents: valid, tag, target, ctr.
- Constants: INIT_NT = 2^(CTR_W−1)−1 (weakly not-taken); INIT_T = 2^(CTR_W−1) (weakly taken). When CTR_W=1, INIT_NT=0 and INIT_T=1.
- Lookup is purely combinational: hit = valid && tag match; taken = hit && ctr[CTR_W−1].
- Mispredict, combinational from upd_* and the current table:
  - Evaluate upd_pc_i as if it were a lookup (p_hit, p_taken, p_target).
  - mispredict_o = upd_valid_i && ((p_taken ≠ upd_taken_i) || (upd_taken_i && p_taken && p_target ≠ upd_target_i)).
  - mispredict_o is 0 when upd_valid_i is 0.
- Update, on the clock edge when upd_valid_i=1:
  - Hit and taken: ctr increments, saturating at all-ones; target ← upd_target_i.
  - Hit and not-taken: ctr decrements, saturating at 0; target unchanged.
  - Miss and taken: allocate the entry, overwriting any alias: valid=1, tag, target, ctr=INIT_T.
  - Miss and not-taken: no change.
- Statistics, on the edge:
  - upd_count_o increments on upd_valid_i.
  - miss_count_o increments on mispredict_o.
  - Both saturate at all-ones and never wrap.
- clear_i: on the edge, every valid bit ← 0 and every ctr ← INIT_NT. Tags and targets become don't-care. Statistics are retained.
- clear_i together with upd_valid_i: clear wins and the table update is dropped. Statistics still count, using the pre-clear mispredict_o.
- Reset (rst_n=0 at an edge), including mid-operation: every valid bit ← 0, every ctr ← INIT_NT, both statistics counters ← 0.
  - Output values after reset: pred_hit_o=0, pred_taken_o=0, pred_target_o=0, mispredict_o=0 until the next update.

## Timing
- Lookup latency is 0 cycles, combinational from if_pc_i.
- An update becomes visible to lookup 1 cycle after the edge that samples it.
- A lookup to the same index in the same cycle as an update returns the old contents; there is no write-through bypass.
- mispredict_o is valid in the same cycle as upd_valid_i.
- One update per cycle; there is no back-pressure and no busy state.
- Statistics reflect the edge they were counted on, 1 cycle later.

## Structure
- Shared package bp_pkg holds:
  - derived widths IDX_W and TAG_W (functions of the parameters);
  - the INIT_NT and INIT_T constants;
  - sat_inc and sat_dec functions, parametrised by width.
- One sub-module, bp_table: the entry array. It has one combinational read port for lookup, one for update evaluation, one synchronous write port, and clear/reset handling.
- The top level holds the mispredict logic, update policy and statistics counters.

## Test plan
All scenarios use ENTRIES=16, CTR_W=2, ADDR_W=32, CNT_W=16 unless stated otherwise.
- After reset, lookup if_pc_i=0x40 → hit=0, taken=0, target=0, upd_count=0, miss_count=0.
- Update pc=0x40, taken, target=0x80 → mispredict_o=1 that cycle. Next cycle, lookup 0x40 → hit=1, taken=1 (ctr=2), target=0x80; miss_count=1, upd_count=1.
- Saturation: on 0x40, apply taken (ctr=3), then taken (stays 3, mispredict_o=0). Then not-taken ×2 → ctr=1, pred_taken=0. Then not-taken ×2 → ctr stays 0.
- Alias: pc 0x80 (index 0, tag 2) updated taken with target=0x100 after the 0x40 entry (index 0, tag 1) exists. Then lookup 0x40 → hit=0, and lookup 0x80 → target=0x100, ctr=2. Taken update with a different target on a predicted-taken hit → mispredict_o=1.
- clear_i and upd_valid_i in the same cycle → next cycle every lookup misses; upd_count increments; miss_count increments if mispredict_o was 1.
- With CNT_W=4, issue 20 mispredicting updates → both counters hold at 15. Then assert rst_n=0 for one edge → both counters 0 and all lookups miss.
